// File: rtl/lut_neuron_pkg.sv
// Shared types and helpers for the run-time loadable, double-buffered LUT neuron.
package lut_neuron_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SWAP  = 2'd2
    } state_t;

    // Table address width: all input activations concatenated.
    function automatic int unsigned calc_addr_w(input int unsigned fan_in,
                                                input int unsigned in_bits);
        return fan_in * in_bits;
    endfunction

endpackage

// File: rtl/lut_neuron_dbuf_bank.sv
// One truth-table bank: synchronous write port, synchronous read port with enable.
module lut_bank_ram #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    (* rom_style = "distributed" *) logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Table contents survive reset so a loaded model outlives a pipeline flush.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/lut_neuron_dbuf.sv
// Loadable LUT neuron: 2-stage valid/ready lookup pipeline over an active/shadow bank pair.
module lut_neuron_dbuf
    import lut_neuron_pkg::*;
#(
    parameter int unsigned FAN_IN   = 4,
    parameter int unsigned IN_BITS  = 2,
    parameter int unsigned OUT_BITS = 2,
    localparam int unsigned ADDR_W  = calc_addr_w(FAN_IN, IN_BITS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ADDR_W-1:0]   in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_BITS-1:0] out_data,
    input  logic                cfg_we,
    input  logic [ADDR_W-1:0]   cfg_addr,
    input  logic [OUT_BITS-1:0] cfg_wdata,
    input  logic                cfg_swap,
    output logic                swap_busy,
    output logic                active_bank
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_a_v;
    logic [ADDR_W-1:0]   r_a_addr;
    logic                r_b_v;
    logic                r_b_sel;
    logic                r_active_bank;

    logic                w_adv_a;
    logic                w_adv_b;
    logic                w_accept;
    logic                w_rd_en;
    logic                w_we0;
    logic                w_we1;
    logic                w_re0;
    logic                w_re1;
    logic [OUT_BITS-1:0] w_rdata0;
    logic [OUT_BITS-1:0] w_rdata1;

    assign w_adv_b  = !r_b_v || out_ready;
    assign w_adv_a  = !r_a_v || w_adv_b;
    assign in_ready = (r_state == ST_RUN) && w_adv_a;
    assign w_accept = in_valid && in_ready;
    assign w_rd_en  = r_a_v && w_adv_b;

    // Config writes always target the bank not used for lookups.
    assign w_we0 = cfg_we && r_active_bank;
    assign w_we1 = cfg_we && !r_active_bank;
    assign w_re0 = w_rd_en && !r_active_bank;
    assign w_re1 = w_rd_en && r_active_bank;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:   if (cfg_swap) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (!r_a_v && !r_b_v) w_state_nxt = ST_SWAP;
            ST_SWAP:  w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active_bank <= 1'b0;
        end else if (r_state == ST_SWAP) begin
            r_active_bank <= !r_active_bank;
        end
    end

    // r_b_sel remembers which bank produced stage B so out_data stays put under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_v    <= 1'b0;
            r_a_addr <= '0;
            r_b_v    <= 1'b0;
            r_b_sel  <= 1'b0;
        end else begin
            if (w_adv_a) begin
                r_a_v <= w_accept;
                if (w_accept) begin
                    r_a_addr <= in_data;
                end
            end
            if (w_adv_b) begin
                r_b_v <= r_a_v;
                if (r_a_v) begin
                    r_b_sel <= r_active_bank;
                end
            end
        end
    end

    lut_bank_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (OUT_BITS)
    ) u_bank0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_we0),
        .i_waddr (cfg_addr),
        .i_wdata (cfg_wdata),
        .i_re    (w_re0),
        .i_raddr (r_a_addr),
        .o_rdata (w_rdata0)
    );

    lut_bank_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (OUT_BITS)
    ) u_bank1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_we1),
        .i_waddr (cfg_addr),
        .i_wdata (cfg_wdata),
        .i_re    (w_re1),
        .i_raddr (r_a_addr),
        .o_rdata (w_rdata1)
    );

    assign out_valid   = r_b_v;
    assign out_data    = r_b_sel ? w_rdata1 : w_rdata0;
    assign swap_busy   = (r_state != ST_RUN);
    assign active_bank = r_active_bank;

endmodule

// File: tb/tb_lut_neuron_dbuf.sv
// Scoreboard bench for lut_neuron_dbuf: directed lookups, backpressure, bank swaps, reset mid-swap.
module tb_lut_neuron_dbuf;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_data;
    logic       cfg_we;
    logic [7:0] cfg_addr;
    logic [1:0] cfg_wdata;
    logic       cfg_swap;
    logic       swap_busy;
    logic       active_bank;

    int         n_checks;
    int         n_fails;
    logic [1:0] exp_q[$];
    logic [1:0] mon_exp;
    longint     t0;
    longint     t1;

    lut_neuron_dbuf dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_swap    (cfg_swap),
        .swap_busy   (swap_busy),
        .active_bank (active_bank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output monitor: every transferred word is matched against the head of the queue.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL unexpected_output: got %0h expected no output at %0t", out_data, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("out_data", 32'(out_data), 32'(mon_exp));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [7:0] a, input logic [1:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic send(input logic [7:0] a, input logic [1:0] e, input bit push);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = a;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 32'(in_ready), 32'd1);
        end else if (push) begin
            exp_q.push_back(e);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_swap();
        int n;
        n = 0;
        cfg_swap = 1'b1;
        tick();
        cfg_swap = 1'b0;
        while (swap_busy && n < 200) begin
            tick();
            n++;
        end
        chk("swap_complete", 32'(swap_busy), 32'd0);
    endtask

    task automatic drain_out();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            tick();
            n++;
        end
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        cfg_we    = 1'b0;
        cfg_addr  = 8'h00;
        cfg_wdata = 2'b00;
        cfg_swap  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_swap_busy", 32'(swap_busy), 32'd0);
        chk("rst_active_bank", 32'(active_bank), 32'd0);

        // Shadow bank 1 gets table[a] = a[1:0].
        for (int i = 0; i < 256; i++) cfg_write(8'(i), 2'(i));

        // Swap with empty pipeline: DRAIN one cycle, SWAP one cycle.
        cfg_swap = 1'b1;
        tick();
        cfg_swap = 1'b0;
        chk("swap_busy_drain", 32'(swap_busy), 32'd1);
        chk("in_ready_drain", 32'(in_ready), 32'd0);
        tick();
        chk("swap_busy_swap", 32'(swap_busy), 32'd1);
        chk("bank_before_toggle", 32'(active_bank), 32'd0);
        tick();
        chk("swap_busy_done", 32'(swap_busy), 32'd0);
        chk("active_bank_after_swap1", 32'(active_bank), 32'd1);

        // Two-edge latency.
        send(8'h05, 2'b01, 1'b1);
        chk("latency_stage_a", 32'(out_valid), 32'd0);
        tick();
        chk("latency_stage_b", 32'(out_valid), 32'd1);
        tick();

        // Full-rate stream through bank 1.
        t0 = $time;
        for (int i = 0; i < 256; i++) send(8'(i), 2'(i), 1'b1);
        t1 = $time;
        chk("stream_cycles", 32'((t1 - t0) / 10), 32'd256);
        drain_out();

        // Bank 0: sparse table.
        for (int i = 0; i < 256; i++) cfg_write(8'(i), 2'b00);
        cfg_write(8'h8C, 2'b01);
        cfg_write(8'hCC, 2'b01);
        cfg_write(8'hCD, 2'b01);
        do_swap();
        chk("active_bank_after_swap2", 32'(active_bank), 32'd0);
        send(8'h8C, 2'b01, 1'b1);
        send(8'hCD, 2'b01, 1'b1);
        send(8'h0C, 2'b00, 1'b1);
        drain_out();

        // Backpressure: only two words fit.
        out_ready = 1'b0;
        send(8'h8C, 2'b01, 1'b1);
        send(8'h0C, 2'b00, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'hCD;
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_out_data", 32'(out_data), 32'd1);
        repeat (3) tick();
        chk("bp_hold_data", 32'(out_data), 32'd1);
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_ready", 32'(in_ready), 32'd0);
        exp_q.push_back(2'b01);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        drain_out();

        // Swap requested mid-stream; second request while busy is dropped.
        send(8'hCC, 2'b01, 1'b1);
        send(8'h8E, 2'b00, 1'b1);
        send(8'hCD, 2'b01, 1'b1);
        cfg_swap = 1'b1;
        send(8'hCC, 2'b01, 1'b1);
        cfg_swap = 1'b0;
        chk("midswap_busy", 32'(swap_busy), 32'd1);
        chk("midswap_in_ready", 32'(in_ready), 32'd0);
        cfg_swap = 1'b1;
        tick();
        cfg_swap = 1'b0;
        send(8'h8E, 2'b10, 1'b1);
        send(8'hCC, 2'b00, 1'b1);
        send(8'h03, 2'b11, 1'b1);
        drain_out();
        chk("midswap_bank", 32'(active_bank), 32'd1);
        chk("midswap_idle", 32'(swap_busy), 32'd0);

        // Write landing in the SWAP cycle is visible right after the swap.
        cfg_swap = 1'b1;
        tick();
        cfg_swap = 1'b0;
        tick();
        chk("swapcyc_busy", 32'(swap_busy), 32'd1);
        chk("swapcyc_bank_old", 32'(active_bank), 32'd1);
        cfg_we    = 1'b1;
        cfg_addr  = 8'h00;
        cfg_wdata = 2'b11;
        tick();
        cfg_we = 1'b0;
        chk("swapcyc_bank_new", 32'(active_bank), 32'd0);
        chk("swapcyc_idle", 32'(swap_busy), 32'd0);
        send(8'h00, 2'b11, 1'b1);
        drain_out();

        // Reset during DRAIN with two words in flight, bank 1 active.
        do_swap();
        chk("pre_reset_bank", 32'(active_bank), 32'd1);
        out_ready = 1'b0;
        send(8'h01, 2'b01, 1'b0);
        send(8'h02, 2'b10, 1'b0);
        cfg_swap = 1'b1;
        tick();
        cfg_swap = 1'b0;
        chk("pre_reset_busy", 32'(swap_busy), 32'd1);
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_data", 32'(out_data), 32'd0);
        chk("arst_swap_busy", 32'(swap_busy), 32'd0);
        chk("arst_active_bank", 32'(active_bank), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("post_reset_valid", 32'(out_valid), 32'd0);
        send(8'h8C, 2'b01, 1'b1);
        send(8'hCD, 2'b01, 1'b1);
        send(8'h00, 2'b11, 1'b1);
        send(8'h0C, 2'b00, 1'b1);
        drain_out();
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/lut_neuron_dbuf.md
# lut_neuron_dbuf

Parametrised, pipelined successor to the combinational per-neuron truth-table modules in the hgcal autoencoder layers. It maps a packed FAN_IN × IN_BITS input vector to an OUT_BITS output by table lookup, but the table is loadable at run time and double-buffered (active + shadow bank), and the datapath is a 2-stage valid/ready pipeline. It sits in place of a generated `layerX_NY` neuron, so one netlist can serve retrained quantised models without regeneration.

## Interface
- FAN_IN, 4, number of input activations per neuron
- IN_BITS, 2, bits per input activation
- OUT_BITS, 2, bits of output activation
- ADDR_W, FAN_IN*IN_BITS (derived, not overridable), table address width; depth = 2**ADDR_W
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  block accepts input this cycle
- in_data  in  ADDR_W  packed inputs, input 0 in bits [IN_BITS-1:0]; used directly as table address
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts output
- out_data  out  OUT_BITS  looked-up activation
- cfg_we  in  1  write one shadow-bank entry
- cfg_addr  in  ADDR_W  shadow-bank entry address
- cfg_wdata  in  OUT_BITS  entry value
- cfg_swap  in  1  request active/shadow exchange (single-cycle pulse)
- swap_busy  out  1  high from accepted swap request until swap completes
- active_bank  out  1  index (0/1) of bank currently used for lookups

## Operation
- Two banks of 2**ADDR_W × OUT_BITS. Lookups read bank `active_bank`; cfg writes go to bank `!active_bank` (sampled in the write cycle). Table contents are not reset.
- Pipeline: stage A holds address + valid (a_v); stage B holds synchronous-read result + valid (b_v). out_valid = b_v, out_data = stage B data.
- adv_b = !b_v | out_ready; adv_a = !a_v | adv_b; in_ready = (state==RUN) & adv_a.
- Input transfer on in_valid & in_ready loads stage A. Stage A moves to B when a_v & adv_b; B reads active bank at a_addr. Stage B cleared on out_ready with no incoming A.
- FSM (enum in package): RUN → DRAIN on cfg_swap in RUN; DRAIN: in_ready=0, wait until a_v=0 & b_v=0 → SWAP; SWAP (one cycle): toggle active_bank → RUN. swap_busy = (state != RUN).
- cfg_swap while swap_busy ignored. cfg_swap with in_valid in the same RUN cycle: that input is accepted (in_ready computed from current state) and is processed with the old bank.
- cfg_we allowed in every state; a write in the SWAP cycle goes to the pre-toggle shadow (becomes active next cycle, write lands first).
- cfg_we to an address being read same cycle: banks are distinct, no hazard.

## Timing
- Reset values: in_ready follows state (RUN) so =1 after reset release; out_valid 0, out_data 0, swap_busy 0, active_bank 0, a_v 0, b_v 0, state RUN.
- Latency: input accepted at edge N appears on out_valid at edge N+2 with out_ready held high. Throughput 1/cycle.
- Backpressure: out_ready low holds out_data/out_valid stable; at most 2 words in flight; in_ready drops when both stages full.
- Swap with empty pipeline: cfg_swap at edge N → DRAIN at N+1, SWAP at N+2, active_bank toggled and RUN at N+3 (swap_busy high for 2 cycles).
- Reset asserted mid-DRAIN/SWAP: immediate return to reset values; in-flight words discarded, bank 0 active, table contents retained.

## Structure
- Package `lut_neuron_pkg`: state enum (RUN, DRAIN, SWAP), helper function for ADDR_W.
- Sub-module `lut_bank_ram`: one bank, sync write, sync read, `rom_style = "distributed"`; instantiated twice, read mux on active_bank.

## Test plan
- Load shadow bank with table[a]=a[1:0] (defaults), swap, stream 0x00..0xFF with out_ready=1 → outputs equal addr[1:0], first at 2 cycles, one per cycle.
- Load bank 0 only entries 0x8C,0xCC,0xCD = 2'b01, rest 0; swap; drive 0x8C,0xCD,0x0C → 01,01,00.
- Hold out_ready=0, offer 3 inputs → exactly 2 accepted, in_ready=0, out_data stable; release → remaining drains in order.
- Stream continuously, pulse cfg_swap mid-stream → inputs before swap use old bank, in_ready=0 until drained, subsequent inputs use new bank; second cfg_swap during busy ignored.
- cfg_we in SWAP cycle to addr 0x00 = 2'b11 → next lookup of 0x00 after swap returns 11.
- Assert rst_n low during DRAIN with 2 words in flight → out_valid=0, swap_busy=0, active_bank=0 asynchronously; after release, previously loaded bank 0 still returns written values.
